// File: rtl/mem_access_ctrl.sv
// Memory access controller: queues read/write requests in a small FIFO and
// replays them to a single-port synchronous memory one strobe at a time.
module mem_access_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 25,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wen,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          mem_cs,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    RSP
  } state_t;

  state_t state, next_state;

  logic          fifo_wen   [DEPTH];
  logic [AW-1:0] fifo_addr  [DEPTH];
  logic [DW-1:0] fifo_wdata [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  logic          mem_cs_nxt, mem_wen_nxt, rsp_valid_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt, rsp_rdata_nxt;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full && !rst;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !empty;
  assign busy      = (state != IDLE) || !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wen[wr_ptr]   <= req_wen;
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_wdata[wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_cs    <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= next_state;
      mem_cs    <= mem_cs_nxt;
      mem_wen   <= mem_wen_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

  // In ISSUE the registered mem_wen still holds the popped request's direction.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!empty) next_state = ISSUE;
      ISSUE:   next_state = mem_wen ? IDLE : RDWAIT;
      RDWAIT:  next_state = RSP;
      RSP:     if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_cs_nxt    = 1'b0;
    mem_wen_nxt   = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    case (state)
      IDLE: begin
        if (!empty) begin
          mem_cs_nxt    = 1'b1;
          mem_wen_nxt   = fifo_wen[rd_ptr];
          mem_addr_nxt  = fifo_addr[rd_ptr];
          mem_wdata_nxt = fifo_wdata[rd_ptr];
        end
      end
      RDWAIT: begin
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = mem_rdata;
      end
      RSP: begin
        if (rsp_ready) rsp_valid_nxt = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: transaction-level timing model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mem_access_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 25;
  localparam int DEPTH = 4;
  localparam int NEVER = 32'h7fffffff;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          busy, mem_cs, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int tests_run = 0;
  int tests_failed = 0;
  int acc_count = 0;
  int rsp_count = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .mem_cs(mem_cs), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory stub: low 6 address bits select a word; the test addresses never alias.
  logic [DW-1:0] mem_store [64];
  initial for (int i = 0; i < 64; i++) mem_store[i] = '0;

  always @(posedge clk) begin
    if (mem_cs && mem_wen)  mem_store[mem_addr[5:0]] <= mem_wdata;
    if (mem_cs && !mem_wen) mem_rdata <= mem_store[mem_addr[5:0]];
  end

  always @(posedge clk) begin
    if (req_valid && req_ready) acc_count <= acc_count + 1;
    if (rsp_valid && rsp_ready) rsp_count <= rsp_count + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: pending requests, and the edge index at which the
  // controller is next free to start one (a write occupies 2 edges, a read
  // holds it until one edge after its response is taken).
  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t          pend[$];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  int            edge_n = 0;
  int            free_edge = 0;
  int            capture_edge = NEVER;
  logic [DW-1:0] pending_rd = '0;
  bit            model_live = 0;
  logic          exp_cs = 0, exp_wen = 0, exp_rvalid = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0, exp_rdata = '0;

  always @(posedge clk) begin : model
    bit   acc;
    req_t r;
    acc = req_valid && !rst && (pend.size() < DEPTH);
    edge_n = edge_n + 1;
    if (rst) begin
      pend.delete();
      free_edge    = edge_n + 1;
      capture_edge = NEVER;
      exp_cs = 0; exp_wen = 0; exp_rvalid = 0;
      exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      model_live = 1;
    end else if (model_live) begin
      exp_cs  = 0;
      exp_wen = 0;
      if (exp_rvalid && rsp_ready) begin
        exp_rvalid = 0;
        free_edge  = edge_n + 1;
      end
      if (capture_edge == edge_n) begin
        exp_rvalid   = 1;
        exp_rdata    = pending_rd;
        capture_edge = NEVER;
      end
      if (pend.size() > 0 && edge_n >= free_edge) begin
        r = pend.pop_front();
        exp_cs = 1; exp_wen = r.wen; exp_addr = r.addr; exp_wdata = r.wdata;
        if (r.wen) begin
          model_mem[r.addr] = r.wdata;
          free_edge = edge_n + 2;
        end else begin
          pending_rd   = model_mem.exists(r.addr) ? model_mem[r.addr] : '0;
          free_edge    = NEVER;
          capture_edge = edge_n + 2;
        end
      end
      if (acc) begin
        r.wen = req_wen; r.addr = req_addr; r.wdata = req_wdata;
        pend.push_back(r);
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("req_ready", req_ready, !rst && (pend.size() < DEPTH));
      checkOutput("mem_cs",    mem_cs,    exp_cs);
      checkOutput("mem_wen",   mem_wen,   exp_wen);
      checkOutput("mem_addr",  mem_addr,  exp_addr);
      checkOutput("mem_wdata", mem_wdata, exp_wdata);
      checkOutput("rsp_valid", rsp_valid, exp_rvalid);
      checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
      checkOutput("busy",      busy,      (pend.size() != 0) || (edge_n + 1 < free_edge));
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  // Offers one request and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int waited = 0;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && waited < 200) begin
      stepCycle();
      waited++;
    end
    checkOutput("accept_wait", req_ready, 1);
    stepCycle();
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int waited = 0;
    while ((busy || rsp_valid) && waited < 300) begin
      stepCycle();
      waited++;
    end
    checkOutput("idle_wait", busy || rsp_valid, 0);
  endtask

  task automatic waitRsp();
    int waited = 0;
    while (!rsp_valid && waited < 300) begin
      stepCycle();
      waited++;
    end
    checkOutput("rsp_wait", rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0, h0;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_mem_cs",    mem_cs, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_busy",      busy, 0);
    checkOutput("rst_mem_addr",  mem_addr, 0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", req_ready, 1);

    // Write then read back one word, checking strobe and response latency.
    applyStimulus(1'b1, 25'h0000005, 16'hA5A5);
    checkOutput("wr_cs_cycle1", mem_cs, 0);
    stepCycle();
    checkOutput("wr_cs",    mem_cs, 1);
    checkOutput("wr_wen",   mem_wen, 1);
    checkOutput("wr_addr",  mem_addr, 25'h0000005);
    checkOutput("wr_wdata", mem_wdata, 16'hA5A5);
    stepCycle();
    checkOutput("wr_cs_drop", mem_cs, 0);
    waitIdle();
    applyStimulus(1'b0, 25'h0000005, 16'h0000);
    checkOutput("rd_valid_lat1", rsp_valid, 0);
    stepCycle();
    checkOutput("rd_cs",  mem_cs, 1);
    checkOutput("rd_wen", mem_wen, 0);
    stepCycle();
    checkOutput("rd_valid_lat2", rsp_valid, 0);
    stepCycle();
    checkOutput("rd_valid_lat3", rsp_valid, 1);
    checkOutput("rd_data_a5a5",  rsp_rdata, 16'hA5A5);
    waitIdle();

    // 24 writes then 24 reads, all in order.
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, AW'(i), DW'(16'h1000 + i));
    h0 = rsp_count;
    for (int i = 0; i < 24; i++) applyStimulus(1'b0, AW'(i), '0);
    waitIdle();
    checkOutput("burst_rsp_count", rsp_count - h0, 24);
    checkOutput("burst_last_data", rsp_rdata, 16'h1017);

    // Backpressure fills the queue: five reads fit, the sixth stalls.
    rsp_ready = 1'b0;
    a0 = acc_count;
    h0 = rsp_count;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_wen = 1'b0; req_addr = AW'(i); req_wdata = '0;
      if (i == 5) checkOutput("full_req_ready", req_ready, 0);
      stepCycle();
    end
    checkOutput("full_accepted", acc_count - a0, 5);
    rsp_ready = 1'b1;
    for (int w = 0; w < 100 && (acc_count - a0) < 6; w++) stepCycle();
    req_valid = 1'b0;
    checkOutput("sixth_accepted", acc_count - a0, 6);
    waitIdle();
    checkOutput("bp_rsp_count", rsp_count - h0, 6);
    checkOutput("bp_last_data", rsp_rdata, 16'h1005);

    // Response held stable under rsp_ready=0, cleared by one handshake.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 25'h0000007, '0);
    waitRsp();
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", rsp_valid, 1);
      checkOutput("hold_data",  rsp_rdata, 16'h1007);
      stepCycle();
    end
    rsp_ready = 1'b1;
    stepCycle();
    checkOutput("hold_cleared", rsp_valid, 0);
    waitIdle();

    // Top-of-range address.
    applyStimulus(1'b1, 25'h1FFFFFF, 16'hFFFF);
    stepCycle();
    checkOutput("max_wr_cs",   mem_cs, 1);
    checkOutput("max_wr_addr", mem_addr, 25'h1FFFFFF);
    waitIdle();
    applyStimulus(1'b0, 25'h1FFFFFF, '0);
    stepCycle();
    checkOutput("max_rd_cs",   mem_cs, 1);
    checkOutput("max_rd_addr", mem_addr, 25'h1FFFFFF);
    waitRsp();
    checkOutput("max_rd_data", rsp_rdata, 16'hFFFF);
    waitIdle();

    // Reset while a read is in RDWAIT with two more queued.
    applyStimulus(1'b0, 25'h0000005, '0);
    applyStimulus(1'b0, 25'h0000006, '0);
    applyStimulus(1'b0, 25'h0000007, '0);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_cs",        mem_cs, 0);
    checkOutput("mid_rst_wen",       mem_wen, 0);
    checkOutput("mid_rst_addr",      mem_addr, 0);
    checkOutput("mid_rst_wdata",     mem_wdata, 0);
    checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
    checkOutput("mid_rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("mid_rst_busy",      busy, 0);
    checkOutput("mid_rst_ready",     req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput("mid_rst_no_rsp", rsp_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
